led_pattern_sequencer: RTL and testbench

//  Run/pause, direction and speed controller for the 2-LED Gray-code rotation pattern on the board.

---
 rtl/led_pattern_sequencer.sv | 148 ++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Debounced run/dir/speed buttons drive an IDLE/RUN/PAUSE FSM that steps a 2-bit Gray LED pattern.
// Button press reaches the outputs DEB_CYC+3 cycles after the raw edge; one step per BASE_DIV>>speed cycles.
module led_pattern_sequencer #(
    parameter int BASE_DIV = 12_500_000,
    parameter int DEB_CYC  = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       btn_speed,
    output logic [1:0] led,
    output logic       running,
    output logic       dir,
    output logic [1:0] speed,
    output logic       step_tick
);
    localparam int DW = $clog2(BASE_DIV);
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0] LAST0 = DW'(BASE_DIV - 1);
    localparam logic [CW-1:0] DEB_N = CW'(DEB_CYC);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Button lanes: bit 0 = run, bit 1 = dir, bit 2 = speed.
    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    last_q, last_d;
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    press_q, press_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    assign btn_raw = {btn_speed, btn_dir, btn_run};

    always_comb begin
        last_d   = sync2_q;
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != last_q[i]) begin
                cnt_d[i] = CW'(1);
            end else if (cnt_q[i] != DEB_N) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            if (cnt_d[i] == DEB_N) begin
                stable_d[i] = sync2_q[i];
            end
        end
        press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            last_q   <= '0;
            stable_q <= '0;
            press_q  <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            last_q   <= last_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    logic [1:0]    state_q, state_d;
    logic [1:0]    led_q, led_d;
    logic [1:0]    speed_q, speed_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] last_cnt;
    logic          run_ev, dir_ev, spd_ev, term;

    assign run_ev = press_q[0];
    assign dir_ev = press_q[1];
    assign spd_ev = press_q[2];

    // BASE_DIV is a multiple of 8, so (BASE_DIV-1)>>s equals (BASE_DIV>>s)-1 for every speed.
    assign last_cnt = LAST0 >> speed_q;
    assign term     = (state_q == ST_RUN) && (div_q == last_cnt);

    function automatic logic [1:0] next_led(input logic [1:0] cur, input logic rev);
        logic [1:0] nxt;
        nxt = 2'b00;
        case (cur)
            2'b00:   nxt = rev ? 2'b01 : 2'b10;
            2'b10:   nxt = rev ? 2'b00 : 2'b11;
            2'b11:   nxt = rev ? 2'b10 : 2'b01;
            default: nxt = rev ? 2'b11 : 2'b00;
        endcase
        return nxt;
    endfunction

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        div_d   = div_q;
        if (state_q == ST_RUN) begin
            div_d = term ? '0 : div_q + DW'(1);
        end
        // A run press on the terminal count pauses instead of stepping.
        if (term && !run_ev) begin
            led_d = next_led(led_q, dir_q);
        end
        if (spd_ev) begin
            speed_d = speed_q + 2'd1;
            div_d   = '0;
        end
        if (dir_ev) begin
            dir_d = ~dir_q;
        end
        if (run_ev) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            led_q   <= 2'b00;
            speed_q <= 2'd0;
            dir_q   <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
        end
    end

    assign led       = led_q;
    assign running   = (state_q == ST_RUN);
    assign dir       = dir_q;
    assign speed     = speed_q;
    assign step_tick = term && !run_ev && !rst;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus random button traffic, checked each cycle
// against a window-based button model and a phase-index LED model.
module tb_led_pattern_sequencer;
    localparam int BASE_DIV = 16;
    localparam int DEB_CYC  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_dir = 1'b0;
    logic       btn_speed = 1'b0;
    logic [1:0] led;
    logic       running;
    logic       dir;
    logic [1:0] speed;
    logic       step_tick;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    led_pattern_sequencer #(.BASE_DIV(BASE_DIV), .DEB_CYC(DEB_CYC)) dut (
        .clk(clk), .rst(rst), .btn_run(btn_run), .btn_dir(btn_dir), .btn_speed(btn_speed),
        .led(led), .running(running), .dir(dir), .speed(speed), .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    // Model: the pattern is a position 0..3 on a ring; gray[] maps position to LEDs.
    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int m_state;   // 0 idle, 1 run, 2 pause
    int m_phase, m_cnt, m_spd;
    bit m_dir;
    bit pipe [3][2];
    bit win  [3][DEB_CYC];
    bit acc  [3];
    bit pend [3];

    always @(posedge clk) begin
        bit raw [3];
        bit ev  [3];
        bit s, all_eq, term;
        int per;
        raw[0] = btn_run; raw[1] = btn_dir; raw[2] = btn_speed;
        if (rst) begin
            m_state = 0; m_phase = 0; m_cnt = 0; m_spd = 0; m_dir = 1'b0;
            for (int b = 0; b < 3; b++) begin
                pipe[b][0] = 1'b0; pipe[b][1] = 1'b0; acc[b] = 1'b0; pend[b] = 1'b0;
                for (int k = 0; k < DEB_CYC; k++) win[b][k] = 1'b0;
            end
        end else begin
            for (int b = 0; b < 3; b++) ev[b] = pend[b];
            per  = BASE_DIV >> m_spd;
            term = (m_state == 1) && (m_cnt == per - 1);
            if (term && !ev[0]) m_phase = m_dir ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
            if (m_state == 1) m_cnt = term ? 0 : m_cnt + 1;
            if (ev[2]) begin m_spd = (m_spd + 1) % 4; m_cnt = 0; end
            if (ev[1]) m_dir = !m_dir;
            if (ev[0]) m_state = (m_state == 1) ? 2 : 1;
            // A level is accepted once the last DEB_CYC synchronised samples agree.
            for (int b = 0; b < 3; b++) begin
                s = pipe[b][1];
                pipe[b][1] = pipe[b][0];
                pipe[b][0] = raw[b];
                for (int k = DEB_CYC - 1; k > 0; k--) win[b][k] = win[b][k-1];
                win[b][0] = s;
                all_eq = 1'b1;
                for (int k = 0; k < DEB_CYC; k++) if (win[b][k] != s) all_eq = 1'b0;
                pend[b] = all_eq && s && !acc[b];
                if (all_eq) acc[b] = s;
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] exp_v, got_v;
        int per;
        if (chk_en) begin
            per   = BASE_DIV >> m_spd;
            exp_v = {gray[m_phase], (m_state == 1), m_dir, m_spd[1:0],
                     (!rst && m_state == 1 && m_cnt == per - 1 && !pend[0])};
            got_v = {led, running, dir, speed, step_tick};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL model_cycle t=%0t got{led,run,dir,spd,tick}=%b expected=%b", $time, got_v, exp_v);
            end
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int mask, input int hold);
        if (mask[0]) btn_run = 1'b1;
        if (mask[1]) btn_dir = 1'b1;
        if (mask[2]) btn_speed = 1'b1;
        cyc(hold);
        btn_run = 1'b0; btn_dir = 1'b0; btn_speed = 1'b0;
    endtask

    // Gap = cycles from the previous tick (call starts one cycle after it); then reads the new LEDs.
    task automatic next_tick(output int gap, output logic [1:0] l);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!step_tick && g < 200);
        if (!step_tick) check("tick_timeout", 0, 1);
        gap = g + 1;
        @(negedge clk);
        l = led;
    endtask

    task automatic step_chk(input string nm, input int exp_gap, input logic [1:0] exp_led);
        int g;
        logic [1:0] l;
        next_tick(g, l);
        check({nm, "_gap"}, g, exp_gap);
        check({nm, "_led"}, int'(l), int'(exp_led));
    endtask

    initial begin
        int n, lat, g, chg, ticks;
        logic [1:0] l, frozen;

        // 1: reset, then idle with no steps
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_running", int'(running), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_speed", int'(speed), 0);
        ticks = 0;
        repeat (100) begin @(negedge clk); if (step_tick) ticks++; end
        check("idle_ticks", ticks, 0);

        // 2: clean run press, steps every 16 cycles, forward sequence
        btn_run = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!running && lat < 20);
        check("run_latency_in_window", int'(lat >= DEB_CYC && lat <= DEB_CYC + 4), 1);
        fork
            begin cyc(3); btn_run = 1'b0; end
            step_chk("t2s1", 16, 2'b10);
        join
        step_chk("t2s2", 16, 2'b11);
        step_chk("t2s3", 16, 2'b01);
        step_chk("t2s4", 16, 2'b00);

        // 3: dir press after the 2nd step
        step_chk("t3a", 16, 2'b10);
        step_chk("t3b", 16, 2'b11);
        fork
            press(2, 8);
            step_chk("t3s1", 16, 2'b10);
        join
        check("t3_dir", int'(dir), 1);
        step_chk("t3s2", 16, 2'b00);
        step_chk("t3s3", 16, 2'b01);

        // 4: speed presses: spacing 8, 4, 2, then back to 16
        for (int k = 1; k <= 4; k++) begin
            press(4, 8);
            cyc(8);
            check("t4_speed", int'(speed), k % 4);
            next_tick(g, l);
            next_tick(g, l);
            check("t4_spacing", g, BASE_DIV >> (k % 4));
        end

        // 5: short glitches on btn_run are ignored, then a real press pauses
        repeat (10) begin
            btn_run = 1'b1;
            cyc($urandom_range(1, 3));
            btn_run = 1'b0;
            cyc($urandom_range(1, 4));
        end
        cyc(8);
        check("t5_still_running", int'(running), 1);
        press(1, 8);
        n = 0;
        while (running && n < 20) begin @(negedge clk); n++; end
        check("t5_paused", int'(running), 0);
        frozen = led;
        chg = 0;
        ticks = 0;
        repeat (50) begin
            @(negedge clk);
            if (led != frozen) chg++;
            if (step_tick) ticks++;
        end
        check("t5_led_frozen", chg, 0);
        check("t5_no_ticks", ticks, 0);

        // 6: reset mid-run at led=11, speed=2
        press(1, 8); cyc(8);
        press(4, 8); cyc(8);
        press(4, 8); cyc(8);
        check("t6_pre_speed", int'(speed), 2);
        n = 0;
        while (!(led == 2'b11 && running) && n < 200) begin @(negedge clk); n++; end
        check("t6_pre_led", int'(led), 3);
        rst = 1'b1;
        @(negedge clk);
        check("t6_led", int'(led), 0);
        check("t6_running", int'(running), 0);
        check("t6_dir", int'(dir), 0);
        check("t6_speed", int'(speed), 0);
        check("t6_tick", int'(step_tick), 0);
        cyc(1);
        rst = 1'b0;
        press(1, 8);
        next_tick(g, l);
        check("t6_rerun_led", int'(l), 2);

        // Random traffic: overlapping presses, bounces and occasional resets
        repeat (300) begin
            press($urandom_range(0, 7), $urandom_range(1, 10));
            cyc($urandom_range(1, 20));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                cyc(2);
                rst = 1'b0;
            end
        end

        cyc(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
